// File: rtl/l2_cache_control_if.sv
// l2_cache_control_if: bus bundle between the L2 sequencing controller and its surroundings.
//   L1 side    : mem_read, mem_write, mem_address (requester drives), mem_resp (controller drives)
//   pmem side  : pmem_read, pmem_write, pmem_address (controller drives), pmem_resp (memory drives)
//   data array : data_index, data_write, data_src, rdata_way (controller drives)
// The controller connects through the slave modport; the requester/environment uses master.
interface l2_cache_control_if #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned INDEX_WIDTH = 4
);
  logic                   mem_read;
  logic                   mem_write;
  logic [ADDR_WIDTH-1:0]  mem_address;
  logic                   mem_resp;
  logic                   pmem_read;
  logic                   pmem_write;
  logic [ADDR_WIDTH-1:0]  pmem_address;
  logic                   pmem_resp;
  logic [INDEX_WIDTH-1:0] data_index;
  logic [1:0]             data_write;
  logic                   data_src;
  logic                   rdata_way;

  modport master (
    output mem_read, mem_write, mem_address, pmem_resp,
    input  mem_resp, pmem_read, pmem_write, pmem_address,
    input  data_index, data_write, data_src, rdata_way
  );

  modport slave (
    input  mem_read, mem_write, mem_address, pmem_resp,
    output mem_resp, pmem_read, pmem_write, pmem_address,
    output data_index, data_write, data_src, rdata_way
  );
endinterface

// File: rtl/l2_cache_control.sv
// l2_cache_control: sequencing controller for a two-way, 16-set L2 cache with 128-bit lines.
// Holds tag/valid/dirty/LRU state, steers the external per-way data arrays and runs
// write-back and fill transactions to physical memory.
// Ports:
//   clk     : clock, all state on posedge
//   reset_n : synchronous active-low reset
//   bus_io  : slave side of l2_cache_control_if (L1 request, pmem, data array controls)
module l2_cache_control #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned OFFSET_WIDTH = 4,
  parameter int unsigned INDEX_WIDTH  = 4,
  parameter int unsigned TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH
) (
  input  logic                clk,
  input  logic                reset_n,
  l2_cache_control_if.slave   bus_io
);

  localparam int unsigned Sets = 1 << INDEX_WIDTH;

  typedef enum logic [1:0] {StIdle, StHit, StWriteback, StFill} state_e;

  state_e                 state_q, state_d;
  logic                   target_q, target_d;
  logic                   is_write_q, is_write_d;
  logic [TAG_WIDTH-1:0]   req_tag_q, req_tag_d;
  logic [INDEX_WIDTH-1:0] index_q, index_d;

  logic [TAG_WIDTH-1:0]   tag_q [2][Sets];
  logic [Sets-1:0]        valid_q [2];
  logic [Sets-1:0]        dirty_q [2];
  logic [Sets-1:0]        lru_q;

  // Array update strobes, all applied to [target_q][index_q]
  logic upd_lru;
  logic line_wr;
  logic line_dirty;
  logic clr_dirty;

  logic [TAG_WIDTH-1:0]   in_tag;
  logic [INDEX_WIDTH-1:0] in_index;
  logic [1:0]             hit;
  logic                   victim;
  logic                   req;
  logic                   unused_offset;

  assign in_tag        = bus_io.mem_address[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign in_index      = bus_io.mem_address[OFFSET_WIDTH +: INDEX_WIDTH];
  assign unused_offset = ^bus_io.mem_address[OFFSET_WIDTH-1:0];
  assign req           = bus_io.mem_read | bus_io.mem_write;

  assign hit[0] = valid_q[0][in_index] && (tag_q[0][in_index] == in_tag);
  assign hit[1] = valid_q[1][in_index] && (tag_q[1][in_index] == in_tag);

  // Fill an invalid way first (way 0 preferred), otherwise evict the LRU way
  assign victim = !valid_q[0][in_index] ? 1'b0 :
                  !valid_q[1][in_index] ? 1'b1 : lru_q[in_index];

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    is_write_d = is_write_q;
    req_tag_d  = req_tag_q;
    index_d    = index_q;
    upd_lru    = 1'b0;
    line_wr    = 1'b0;
    line_dirty = 1'b0;
    clr_dirty  = 1'b0;

    bus_io.mem_resp     = 1'b0;
    bus_io.pmem_read    = 1'b0;
    bus_io.pmem_write   = 1'b0;
    bus_io.pmem_address = '0;
    bus_io.data_write   = 2'b00;
    bus_io.data_src     = 1'b0;
    bus_io.rdata_way    = 1'b0;
    bus_io.data_index   = (state_q == StIdle) ? in_index : index_q;
    if (!reset_n) begin
      bus_io.data_index = '0;
    end

    unique case (state_q)
      StIdle: begin
        if (req) begin
          index_d    = in_index;
          req_tag_d  = in_tag;
          // Simultaneous read and write is handled as a write
          is_write_d = bus_io.mem_write;
          if (|hit) begin
            target_d = ~hit[0];
            state_d  = StHit;
          end else begin
            target_d = victim;
            if (valid_q[victim][in_index] && dirty_q[victim][in_index]) begin
              state_d = StWriteback;
            end else if (bus_io.mem_write) begin
              // Full-line write overwrites everything, no fetch required
              state_d = StHit;
            end else begin
              state_d = StFill;
            end
          end
        end
      end

      StHit: begin
        bus_io.mem_resp  = 1'b1;
        bus_io.rdata_way = target_q;
        upd_lru          = 1'b1;
        if (is_write_q) begin
          bus_io.data_write = target_q ? 2'b10 : 2'b01;
          line_wr           = 1'b1;
          line_dirty        = 1'b1;
        end
        state_d = StIdle;
      end

      StWriteback: begin
        bus_io.pmem_write   = 1'b1;
        bus_io.pmem_address = {tag_q[target_q][index_q], index_q, {OFFSET_WIDTH{1'b0}}};
        bus_io.rdata_way    = target_q;
        if (bus_io.pmem_resp) begin
          clr_dirty = 1'b1;
          state_d   = is_write_q ? StHit : StFill;
        end
      end

      StFill: begin
        bus_io.pmem_read    = 1'b1;
        bus_io.pmem_address = {req_tag_q, index_q, {OFFSET_WIDTH{1'b0}}};
        if (bus_io.pmem_resp) begin
          bus_io.data_write = target_q ? 2'b10 : 2'b01;
          bus_io.data_src   = 1'b1;
          line_wr           = 1'b1;
          line_dirty        = 1'b0;
          state_d           = StHit;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      target_q   <= 1'b0;
      is_write_q <= 1'b0;
      req_tag_q  <= '0;
      index_q    <= '0;
      valid_q    <= '{default: '0};
      dirty_q    <= '{default: '0};
      lru_q      <= '0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      is_write_q <= is_write_d;
      req_tag_q  <= req_tag_d;
      index_q    <= index_d;
      if (upd_lru) begin
        lru_q[index_q] <= ~target_q;
      end
      if (line_wr) begin
        valid_q[target_q][index_q] <= 1'b1;
        dirty_q[target_q][index_q] <= line_dirty;
      end else if (clr_dirty) begin
        dirty_q[target_q][index_q] <= 1'b0;
      end
    end
  end

  // Tags are meaningless while invalid, so they are not cleared by reset
  always_ff @(posedge clk) begin
    if (reset_n && line_wr) begin
      tag_q[target_q][index_q] <= req_tag_q;
    end
  end

endmodule

// File: tb/tb_l2_cache_control.sv
module tb_l2_cache_control;
  logic clk = 1'b0;
  logic reset_n;

  l2_cache_control_if bus ();

  l2_cache_control dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Called just after the edge entering WRITEBACK/FILL; checks strobes/address,
  // holds for 'hold' cycles, then raises pmem_resp.
  task automatic expect_pmem(input string tag, input logic [1:0] strb, input logic [15:0] addr,
                             input int hold);
    settle();
    check_eq({tag, "_strb"}, {30'd0, bus.pmem_read, bus.pmem_write}, {30'd0, strb});
    check_eq({tag, "_addr"}, {16'd0, bus.pmem_address}, {16'd0, addr});
    for (int i = 0; i < hold; i++) begin
      tick();
      settle();
      check_eq({tag, "_hold"}, {29'd0, bus.pmem_read, bus.pmem_write, bus.mem_resp},
               {29'd0, strb, 1'b0});
    end
    bus.pmem_resp = 1'b1;
    settle();
  endtask

  // Called just after the edge entering HIT; checks the response cycle, then drops the request.
  task automatic expect_hit(input string tag, input logic way, input logic [2:0] dw_src);
    settle();
    check_eq({tag, "_resp"}, {31'd0, bus.mem_resp}, 32'd1);
    check_eq({tag, "_way"}, {31'd0, bus.rdata_way}, {31'd0, way});
    check_eq({tag, "_dw"}, {29'd0, bus.data_write, bus.data_src}, {29'd0, dw_src});
    check_eq({tag, "_nopmem"}, {30'd0, bus.pmem_read, bus.pmem_write}, 32'd0);
    tick();
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    settle();
    check_eq({tag, "_onepulse"}, {31'd0, bus.mem_resp}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ctl"}, {25'd0, bus.mem_resp, bus.pmem_read, bus.pmem_write,
             bus.data_write, bus.data_src, bus.rdata_way}, 32'd0);
    check_eq({tag, "_paddr"}, {16'd0, bus.pmem_address}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n         = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_address = 16'h1230;
    bus.pmem_resp   = 1'b0;
    tick();
    tick();
    settle();
    check_eq("rst_index", {28'd0, bus.data_index}, 32'd0);
    check_all_zero("rst");

    reset_n         = 1'b1;
    bus.mem_address = 16'h0000;
    tick();

    // Stray pmem_resp in IDLE must be ignored
    bus.pmem_resp = 1'b1;
    tick();
    bus.pmem_resp = 1'b0;
    settle();
    check_all_zero("stray_resp");

    // Read miss into empty set 3 -> fill way 0
    bus.mem_read    = 1'b1;
    bus.mem_address = 16'h1230;
    settle();
    check_eq("t1_index", {28'd0, bus.data_index}, 32'h3);
    check_all_zero("t1_idle");
    tick();
    expect_pmem("t1_fill", 2'b10, 16'h1230, 2);
    check_eq("t1_fill_dw", {29'd0, bus.data_write, bus.data_src}, 32'b011);
    tick();
    bus.pmem_resp = 1'b0;
    expect_hit("t1_hit", 1'b0, 3'b000);

    // Reread hits way 0 without pmem traffic
    bus.mem_read    = 1'b1;
    bus.mem_address = 16'h1230;
    tick();
    expect_hit("t2_hit", 1'b0, 3'b000);

    // Write miss, way 1 invalid -> straight to HIT, write way 1 from L1 data
    bus.mem_write   = 1'b1;
    bus.mem_address = 16'h4530;
    tick();
    expect_hit("t3_hit", 1'b1, 3'b100);

    // Set full, lru = 0, way 0 clean -> fill only, into way 0
    bus.mem_read    = 1'b1;
    bus.mem_address = 16'h7830;
    tick();
    expect_pmem("t4_fill", 2'b10, 16'h7830, 0);
    check_eq("t4_fill_dw", {29'd0, bus.data_write, bus.data_src}, 32'b011);
    tick();
    bus.pmem_resp = 1'b0;
    expect_hit("t4_hit", 1'b0, 3'b000);

    // lru = 1, way 1 dirty (0x45) -> write back 0x4530, then fill 0x9930
    bus.mem_read    = 1'b1;
    bus.mem_address = 16'h9930;
    tick();
    expect_pmem("t4b_wb", 2'b01, 16'h4530, 1);
    check_eq("t4b_wb_way", {29'd0, bus.data_write, bus.rdata_way}, 32'b001);
    tick();
    bus.pmem_resp = 1'b0;
    expect_pmem("t4b_fill", 2'b10, 16'h9930, 0);
    check_eq("t4b_fill_dw", {29'd0, bus.data_write, bus.data_src}, 32'b101);
    tick();
    bus.pmem_resp = 1'b0;
    expect_hit("t4b_hit", 1'b1, 3'b000);

    // Reset during FILL aborts it; set 3 is then empty so 0x1230 misses
    bus.mem_read    = 1'b1;
    bus.mem_address = 16'h1230;
    tick();
    settle();
    check_eq("t5_fill", {30'd0, bus.pmem_read, bus.pmem_write}, 32'b10);
    reset_n      = 1'b0;
    bus.mem_read = 1'b0;
    tick();
    settle();
    check_all_zero("t5_abort");
    reset_n = 1'b1;
    tick();
    bus.mem_read    = 1'b1;
    bus.mem_address = 16'h1230;
    settle();
    check_eq("t5_idle_resp", {31'd0, bus.mem_resp}, 32'd0);
    tick();
    expect_pmem("t5_miss", 2'b10, 16'h1230, 0);
    check_eq("t5_miss_dw", {29'd0, bus.data_write, bus.data_src}, 32'b011);
    tick();
    bus.pmem_resp = 1'b0;
    expect_hit("t5_hit", 1'b0, 3'b000);

    // Read+write together acts as write: no fetch, L1 data, line dirty
    bus.mem_read    = 1'b1;
    bus.mem_write   = 1'b1;
    bus.mem_address = 16'h2250;
    tick();
    expect_hit("t6_hit", 1'b0, 3'b010);
    bus.mem_read    = 1'b1;
    bus.mem_address = 16'h3350;
    tick();
    expect_pmem("t6b_fill", 2'b10, 16'h3350, 0);
    check_eq("t6b_fill_dw", {29'd0, bus.data_write, bus.data_src}, 32'b101);
    tick();
    bus.pmem_resp = 1'b0;
    expect_hit("t6b_hit", 1'b1, 3'b000);
    // Way 0 (0x22) is LRU and must be dirty -> write back first
    bus.mem_read    = 1'b1;
    bus.mem_address = 16'h4450;
    tick();
    expect_pmem("t6c_wb", 2'b01, 16'h2250, 0);
    tick();
    bus.pmem_resp = 1'b0;
    expect_pmem("t6c_fill", 2'b10, 16'h4450, 0);
    tick();
    bus.pmem_resp = 1'b0;
    expect_hit("t6c_hit", 1'b0, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/l2_cache_control.md
# l2_cache_control

Sequencing controller for the two-way, 16-set unified L2 cache built from two 128-bit data-array instances, one per way. It sits between the L1 caches' line-granular memory port and physical memory. It holds the tag, valid, dirty and LRU state internally. It drives index, per-way write enables and source/way selects to the external data arrays and muxes, and runs write-back and fill transactions to physical memory.

## Interface
Parameters:
- ADDR_WIDTH, 16, byte address width (lc3b_word)
- OFFSET_WIDTH, 4, byte offset within a 128-bit line
- INDEX_WIDTH, 4, set index width (lc3b_cl2_index)
- TAG_WIDTH, ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH (8), stored tag width

Ports:
- clk  in  1  clock; all state updates on posedge
- reset_n  in  1  reset; synchronous, active-low
- mem_read  in  1  L1 line read request; held until mem_resp
- mem_write  in  1  L1 full-line write request; held until mem_resp
- mem_address  in  16  request address; offset bits ignored
- mem_resp  out  1  one-cycle completion pulse to L1
- pmem_read  out  1  physical memory line read; held until pmem_resp
- pmem_write  out  1  physical memory line write; held until pmem_resp
- pmem_address  out  16  line address, low 4 bits always 0
- pmem_resp  in  1  physical memory completion
- data_index  out  4  index to both data arrays
- data_write  out  2  per-way data array write enable
- data_src  out  1  data array input select: 0 = L1 write data, 1 = pmem read data
- rdata_way  out  1  way feeding L1 read data and pmem write data mux

## Operation
- Address split: tag = addr[15:8], index = addr[7:4].
- Hit: valid[w][index] && tag[w][index] == req tag. Computed combinationally from internal arrays.
- Victim way selection, in priority order: first invalid way (way 0 before way 1); otherwise lru[index]. lru[index] names the least-recently-used way.
- States: IDLE, HIT, WRITEBACK, FILL. Reset state is IDLE.
- IDLE:
  - No request: stay in IDLE.
  - Request that hits: latch target = hit way, go to HIT.
  - Request that misses: latch target = victim, latch request tag/index.
    - Victim valid and dirty: go to WRITEBACK.
    - Read miss with clean or invalid victim: go to FILL.
    - Write miss with clean or invalid victim: go directly to HIT. A full-line write needs no fetch.
- HIT:
  - mem_resp = 1 and rdata_way = target.
  - lru[index] <= ~target.
  - If write: data_write[target] = 1, data_src = 0, tag <= req tag, valid <= 1, dirty <= 1.
  - Next state is IDLE unconditionally.
- WRITEBACK:
  - pmem_write = 1, pmem_address = {victim tag, index, 4'b0}, rdata_way = target.
  - On pmem_resp: clear dirty[target][index]. Go to FILL if read, HIT if write.
- FILL:
  - pmem_read = 1, pmem_address = {req tag, index, 4'b0}.
  - On pmem_resp: data_write[target] = 1, data_src = 1, tag <= req tag, valid <= 1, dirty <= 0. Go to HIT.
- mem_read and mem_write both asserted: treated as a write.
- data_index equals the latched index outside IDLE, and mem_address index in IDLE.

## Timing
- Reset:
  - Whole-array clear in one cycle: all valid, dirty and lru cleared.
  - State returns to IDLE.
  - All outputs 0 the cycle after reset_n is sampled low. data_index is 0 during reset.
  - Reset mid-WRITEBACK or mid-FILL aborts the transaction; pmem strobes deassert next cycle.
- Read/write hit: request seen in IDLE at cycle 0; mem_resp in cycle 1. Latency 2 cycles to the next acceptance.
- Read miss, clean victim: FILL from cycle 1 until the pmem_resp cycle N; HIT in N+1.
- Read miss, dirty victim: WRITEBACK, then FILL, then HIT. pmem_write and pmem_read are never asserted together.
- Write miss, dirty victim: WRITEBACK, then HIT; no pmem_read.
- pmem_resp ignored outside WRITEBACK and FILL.
- mem_resp is exactly one cycle. The requester drops its request at the edge ending mem_resp.
- data_write is asserted at most one cycle per transaction phase, never for both ways.

## Test plan
- Reset, then read 0x1230 → FILL with pmem_address 0x1230. After pmem_resp: data_write = 01, data_src = 1, then mem_resp; valid[0][3] = 1, lru[3] = 1.
- Reread 0x1230 → no pmem activity; mem_resp on cycle 1 with rdata_way = 0.
- Write 0x4530 (miss, way 1 invalid) → no pmem traffic; data_write = 10, data_src = 0, mem_resp; dirty[1][3] = 1.
- Read 0x7830 (set 3 full, lru = 0, way 0 clean) → FILL only, into way 0. Then read 0x9930 → victim way 1 is dirty: pmem_write to 0x4530, then pmem_read to 0x9930, then mem_resp.
- Assert reset_n = 0 during FILL with pmem_resp never arriving → pmem_read drops next cycle; a subsequent read of 0x1230 misses.
- Assert mem_read and mem_write together on an address → behaves as a write (data_src = 0, dirty set).
